// File: rtl/instr_enc_if.sv
// Handshake bundle for instr_enc.
//   Request side : in_valid/in_ready plus op_id, rs, rt, rd, shamt, imm.
//   Result side  : out_valid/out_ready plus out_word, out_last.
//   Status       : err_illegal (one-cycle pulse), err_count (saturating).
// master = producer/consumer environment, slave = the encoder.
interface instr_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op_id;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
  logic        err_illegal;
  logic [7:0]  err_count;

  modport master (
    output in_valid, op_id, rs, rt, rd, shamt, imm, out_ready,
    input  in_ready, out_valid, out_word, out_last, err_illegal, err_count
  );

  modport slave (
    input  in_valid, op_id, rs, rt, rd, shamt, imm, out_ready,
    output in_ready, out_valid, out_word, out_last, err_illegal, err_count
  );
endinterface

// File: rtl/instr_enc.sv
// Streaming MIPS-subset instruction encoder.
// Packs a mnemonic ID plus operand fields into R/I/J-type words, expands the LI
// pseudo-instruction into LUI+ORI, and queues results in a DEPTH-entry FIFO.
// Illegal mnemonics are consumed, emit no word, and are flagged/counted.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - instr_enc_if.slave (request handshake, result handshake, error status)
module instr_enc #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  instr_enc_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StLi2} state_e;
  typedef enum logic [2:0] {KindR, KindI, KindJ, KindLi, KindNop, KindIll} kind_e;

  state_e            state_q;
  logic [4:0]        li_rt_q;
  logic [15:0]       li_lo_q;
  logic [32:0]       mem_q [DEPTH];  // {last, word}
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              err_illegal_q;
  logic [7:0]        err_count_q;

  kind_e       kind;
  logic [5:0]  opc;
  logic [5:0]  funct;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [31:0] enc_word;

  logic        has_room;
  logic        in_ready;
  logic        accept;
  logic        push;
  logic        pop;
  logic [32:0] push_entry;

  // Decode mnemonic into format, opcode/funct and field overrides.
  always_comb begin
    kind  = KindR;
    opc   = 6'h00;
    funct = 6'h00;
    f_rs  = bus.rs;
    f_rt  = bus.rt;
    case (bus.op_id)
      6'd0:  funct = 6'h00;
      6'd1:  funct = 6'h02;
      6'd2:  funct = 6'h03;
      6'd3:  funct = 6'h04;
      6'd4:  funct = 6'h06;
      6'd5:  funct = 6'h07;
      6'd6:  funct = 6'h20;
      6'd7:  funct = 6'h21;
      6'd8:  funct = 6'h22;
      6'd9:  funct = 6'h23;
      6'd10: funct = 6'h24;
      6'd11: funct = 6'h25;
      6'd12: funct = 6'h26;
      6'd13: funct = 6'h27;
      6'd14: funct = 6'h2A;
      6'd15: funct = 6'h2B;
      6'd16: funct = 6'h08;
      6'd17: funct = 6'h09;
      6'd18: begin kind = KindI; opc = 6'h23; end
      6'd19: begin kind = KindI; opc = 6'h2B; end
      6'd20: begin kind = KindI; opc = 6'h08; end
      6'd21: begin kind = KindI; opc = 6'h09; end
      6'd22: begin kind = KindI; opc = 6'h0A; end
      6'd23: begin kind = KindI; opc = 6'h0B; end
      6'd24: begin kind = KindI; opc = 6'h0C; end
      6'd25: begin kind = KindI; opc = 6'h0D; end
      6'd26: begin kind = KindI; opc = 6'h0E; end
      6'd27: begin kind = KindI; opc = 6'h0F; f_rs = 5'd0; end
      // REGIMM branches select the condition through the rt field.
      6'd28: begin kind = KindI; opc = 6'h01; f_rt = 5'd0; end
      6'd29: begin kind = KindI; opc = 6'h01; f_rt = 5'd1; end
      6'd30: begin kind = KindI; opc = 6'h04; end
      6'd31: begin kind = KindI; opc = 6'h05; end
      6'd32: begin kind = KindI; opc = 6'h06; f_rt = 5'd0; end
      6'd33: begin kind = KindI; opc = 6'h07; f_rt = 5'd0; end
      6'd34: begin kind = KindJ; opc = 6'h02; end
      6'd35: begin kind = KindJ; opc = 6'h03; end
      6'd36: kind = KindLi;
      6'd37: kind = KindNop;
      default: kind = KindIll;
    endcase
  end

  always_comb begin
    enc_word = 32'h0;
    case (kind)
      KindR:   enc_word = {6'h00, bus.rs, bus.rt, bus.rd, bus.shamt, funct};
      KindI:   enc_word = {opc, f_rs, f_rt, bus.imm[15:0]};
      KindJ:   enc_word = {opc, bus.imm[25:0]};
      KindLi:  enc_word = {6'h0F, 5'd0, bus.rt, bus.imm[31:16]};
      default: enc_word = 32'h0;
    endcase
  end

  // Push eligibility looks only at the registered count; a same-cycle pop gives no credit.
  always_comb begin
    has_room = (count_q < DepthCnt);
    in_ready = (state_q == StIdle) && has_room;
    accept   = bus.in_valid && in_ready;
    pop      = (count_q != '0) && bus.out_ready;
    push     = 1'b0;
    push_entry = {1'b1, enc_word};
    if (state_q == StLi2) begin
      push       = has_room;
      push_entry = {1'b1, 6'h0D, li_rt_q, li_rt_q, li_lo_q};
    end else begin
      push       = accept && (kind != KindIll);
      push_entry = {(kind != KindLi), enc_word};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      li_rt_q       <= '0;
      li_lo_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_illegal_q <= 1'b0;
      err_count_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      err_illegal_q <= 1'b0;

      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (kind == KindIll) begin
              err_illegal_q <= 1'b1;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
            end
            if (kind == KindLi) begin
              state_q <= StLi2;
              li_rt_q <= bus.rt;
              li_lo_q <= bus.imm[15:0];
            end
          end
        end
        StLi2: begin
          if (has_room) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (count_q != '0);
  // Empty FIFO presents zeros rather than a stale entry.
  assign bus.out_word    = (count_q != '0) ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign bus.out_last    = (count_q != '0) ? mem_q[rd_ptr_q][32] : 1'b0;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_instr_enc.sv
// Directed self-checking bench for instr_enc (DEPTH = 4).
module tb_instr_enc;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  instr_enc_if bus ();

  instr_enc #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.op_id     = 6'd0;
    bus.rs        = 5'd0;
    bus.rt        = 5'd0;
    bus.rd        = 5'd0;
    bus.shamt     = 5'd0;
    bus.imm       = 32'h0;
    bus.out_ready = 1'b0;
  endtask

  // Presents one request at a negedge and returns at the negedge after it was accepted.
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
    bus.op_id    = op;
    bus.rs       = rs;
    bus.rt       = rt;
    bus.rd       = rd;
    bus.shamt    = sh;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64 && !bus.in_ready; i++) @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_accept op=%0d in_ready=%b required 1", op, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.out_word !== 32'h0) begin fails++;
      $display("FAIL reset_out_word got=%h exp=00000000", bus.out_word); end
    tests++; if (bus.out_last !== 1'b0) begin fails++;
      $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
    tests++; if (bus.err_illegal !== 1'b0) begin fails++;
      $display("FAIL reset_err_illegal got=%b exp=0", bus.err_illegal); end
    tests++; if (bus.err_count !== 8'd0) begin fails++;
      $display("FAIL reset_err_count got=%0d exp=0", bus.err_count); end
    rst_n = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_encode();
    logic [5:0]  ops [12] = '{6'd6, 6'd0, 6'd17, 6'd29, 6'd28, 6'd27,
                              6'd20, 6'd35, 6'd37, 6'd5, 6'd33, 6'd19};
    logic [4:0]  rss [12] = '{5'd4, 5'd0, 5'd31, 5'd4, 5'd4, 5'd7,
                              5'd1, 5'd0, 5'd1, 5'd1, 5'd2, 5'd29};
    logic [4:0]  rts [12] = '{5'd5, 5'd3, 5'd0, 5'd9, 5'd9, 5'd3,
                              5'd2, 5'd0, 5'd2, 5'd2, 5'd7, 5'd31};
    logic [4:0]  rds [12] = '{5'd4, 5'd2, 5'd31, 5'd0, 5'd0, 5'd0,
                              5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd0};
    logic [4:0]  shs [12] = '{5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0,
                              5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0};
    logic [31:0] ims [12] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'hABCD,
                              32'hFFFF8000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                              32'h10, 32'hFFFC};
    logic [31:0] exp [12] = '{32'h00852020, 32'h00031100, 32'h03E0F809, 32'h04810004,
                              32'h04800004, 32'h3C03ABCD, 32'h20228000, 32'h0FFFFFFF,
                              32'h00000000, 32'h00221807, 32'h1C400010, 32'hAFBFFFFC};
    for (int i = 0; i < 12; i++) begin
      send(ops[i], rss[i], rts[i], rds[i], shs[i], ims[i]);
      tests++; if (bus.out_valid !== 1'b1) begin fails++;
        $display("FAIL encode_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      tests++; if (bus.out_word !== exp[i]) begin fails++;
        $display("FAIL encode_word[%0d] op=%0d got=%h exp=%h", i, ops[i], bus.out_word, exp[i]);
      end
      tests++; if (bus.out_last !== 1'b1) begin fails++;
        $display("FAIL encode_last[%0d] got=%b exp=1", i, bus.out_last); end
      pop_one();
      tests++; if (bus.out_valid !== 1'b0) begin fails++;
        $display("FAIL encode_drain[%0d] out_valid got=%b exp=0", i, bus.out_valid); end
    end
  endtask

  task automatic test_order();
    send(6'd18, 5'd4, 5'd5, 5'd0, 5'd0, 32'h4);
    send(6'd34, 5'd0, 5'd0, 5'd0, 5'd0, 32'h9);
    tests++; if (bus.out_word !== 32'h8C850004) begin fails++;
      $display("FAIL order_first got=%h exp=8C850004", bus.out_word); end
    pop_one();
    tests++; if (bus.out_word !== 32'h08000009) begin fails++;
      $display("FAIL order_second got=%h exp=08000009", bus.out_word); end
    pop_one();
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL order_empty out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_li();
    send(6'd36, 5'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    // Change inputs to show word 2 comes from values latched at acceptance.
    bus.rt  = 5'd31;
    bus.imm = 32'h0;
    tests++; if (bus.in_ready !== 1'b0) begin fails++;
      $display("FAIL li2_in_ready got=%b exp=0", bus.in_ready); end
    tests++; if (bus.out_word !== 32'h3C051234 || bus.out_last !== 1'b0) begin fails++;
      $display("FAIL li_word1 got=%h/%b exp=3C051234/0", bus.out_word, bus.out_last); end
    @(negedge clk);
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL li_back_idle in_ready got=%b exp=1", bus.in_ready); end
    tests++; if (bus.out_word !== 32'h3C051234) begin fails++;
      $display("FAIL li_hold got=%h exp=3C051234", bus.out_word); end
    pop_one();
    tests++; if (bus.out_word !== 32'h34A55678 || bus.out_last !== 1'b1) begin fails++;
      $display("FAIL li_word2 got=%h/%b exp=34A55678/1", bus.out_word, bus.out_last); end
    pop_one();
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL li_empty out_valid got=%b exp=0", bus.out_valid); end
    // Zero upper half still yields two words.
    send(6'd36, 5'd0, 5'd2, 5'd0, 5'd0, 32'h00000042);
    tests++; if (bus.out_word !== 32'h3C020000 || bus.out_last !== 1'b0) begin fails++;
      $display("FAIL li0_word1 got=%h/%b exp=3C020000/0", bus.out_word, bus.out_last); end
    pop_one();
    tests++; if (bus.out_word !== 32'h34420042 || bus.out_last !== 1'b1) begin fails++;
      $display("FAIL li0_word2 got=%h/%b exp=34420042/1", bus.out_word, bus.out_last); end
    pop_one();
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL li0_empty out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_full();
    logic [31:0] w [5];
    for (int k = 0; k < 5; k++) w[k] = 32'h00850020 | (32'(k + 1) << 11);
    for (int k = 0; k < 4; k++) send(6'd6, 5'd4, 5'd5, 5'(k + 1), 5'd0, 32'h0);
    bus.rd       = 5'd5;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tests++; if (bus.in_ready !== 1'b0) begin fails++;
        $display("FAIL full_in_ready[%0d] got=%b exp=0", c, bus.in_ready); end
      tests++; if (bus.out_word !== w[0]) begin fails++;
        $display("FAIL full_hold[%0d] got=%h exp=%h", c, bus.out_word, w[0]); end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.out_valid !== 1'b1 || bus.out_word !== w[i]) begin fails++;
        $display("FAIL full_drain[%0d] got=%h/%b exp=%h/1", i, bus.out_word, bus.out_valid, w[i]);
      end
      if (i == 0) bus.out_ready = 1'b1;
      if (i == 1) begin
        tests++; if (bus.in_ready !== 1'b1) begin fails++;
          $display("FAIL full_reopen in_ready got=%b exp=1", bus.in_ready); end
      end
      if (i == 2) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL full_empty out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(6'd6, 5'd4, 5'd5, 5'(k + 8), 5'd0, 32'h0);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_word !== (32'h00850020 | (32'(k + 8) << 11))) begin
        fails++;
        $display("FAIL b2b_word[%0d] got=%h/%b exp=%h/1", k, bus.out_word, bus.out_valid,
                 32'h00850020 | (32'(k + 8) << 11));
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL b2b_empty out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    send(6'd50, 5'd1, 5'd2, 5'd3, 5'd4, 32'h1);
    tests++; if (bus.err_illegal !== 1'b1) begin fails++;
      $display("FAIL ill_pulse got=%b exp=1", bus.err_illegal); end
    tests++; if (bus.err_count !== 8'd1) begin fails++;
      $display("FAIL ill_count got=%0d exp=1", bus.err_count); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL ill_no_word out_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk);
    tests++; if (bus.err_illegal !== 1'b0) begin fails++;
      $display("FAIL ill_pulse_end got=%b exp=0", bus.err_illegal); end
    for (int i = 0; i < 253; i++) send(6'd63, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    tests++; if (bus.err_count !== 8'd254) begin fails++;
      $display("FAIL ill_count254 got=%0d exp=254", bus.err_count); end
    for (int i = 0; i < 3; i++) send(6'd38, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    tests++; if (bus.err_count !== 8'd255) begin fails++;
      $display("FAIL ill_saturate got=%0d exp=255", bus.err_count); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL ill_still_empty out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_li();
    send(6'd36, 5'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_word !== 32'h0 || bus.out_last !== 1'b0)
    begin fails++;
      $display("FAIL rstli_flush got=%h/%b/%b exp=00000000/0/0", bus.out_word, bus.out_valid,
               bus.out_last);
    end
    tests++; if (bus.err_count !== 8'd0) begin fails++;
      $display("FAIL rstli_err_count got=%0d exp=0", bus.err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL rstli_no_word2 out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL rstli_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_order();
    test_li();
    test_full();
    test_back_to_back();
    test_illegal();
    test_reset_mid_li();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
